rv_memory: RTL and testbench
============================

Name: rv_memory

Overview:
- Memory-access stage of the 5-stage RV32I pipeline. Sits between execute and rv_write.
- Registers execute-stage results and runs load/store transactions on the data bus (req/ack, variable wait states).
- Aligns store data and generates byte enables.
- Stalls the front of the pipeline while an access is outstanding. Raises an access fault on misalignment or bus timeout.
- Passes raw 32-bit read data to rv_write, which does byte/half extraction and sign extension.

Parameters:
- TIMEOUT, 255: max wait cycles for i_dbus_ack before an access fault. Range 1..255, 8-bit counter.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_flush  in  1  replace the stage contents with a bubble
- i_alu_result  in  32  effective address, or ALU result
- i_wdata  in  32  store source (rs2)
- i_mem_read  in  1  load instruction
- i_mem_write  in  1  store instruction
- i_reg_write  in  1  rd write enable
- i_rd  in  5  destination register
- i_res_src  in  2  result select (RESULT_SRC_*)
- i_pc_p4  in  30  PC+4 [31:2]
- i_funct3  in  3  load/store size and sign
- o_stall  out  1  upstream must hold its state
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  write strobe
- o_dbus_addr  out  30  word address [31:2]
- o_dbus_be  out  4  byte enables
- o_dbus_wdata  out  32  lane-aligned store data
- i_dbus_rdata  in  32  read data, valid with ack
- i_dbus_ack  in  1  transfer complete
- o_data  out  32  raw read data to rv_write
- o_alu_result, o_reg_write, o_rd, o_res_src, o_pc_p4, o_funct3  out  32/1/5/2/30/3  to rv_write
- o_fault  out  1  one-cycle access-fault pulse
- o_fault_addr  out  32  faulting address

Behaviour:
- Reset: the pipeline register clears to a bubble (all fields 0); state is IDLE; counter 0. All outputs are 0, including o_stall, o_dbus_req and o_fault.
- Pipeline register load rules:
  - It loads from the inputs on each rising edge when o_stall=0.
  - When i_flush=1, it loads a bubble instead. i_flush has priority over the inputs.
  - When o_stall=1, i_flush is ignored.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY: on the same edge that loads a mem op that is aligned and not flushed.
  - BUSY -> IDLE: on i_dbus_ack or on timeout.
- Bus outputs:
  - o_dbus_req = (state==BUSY). o_dbus_we = r_mem_write.
  - addr, be and wdata are derived from the registered fields and stay stable for the whole of BUSY.
- Store alignment, using a = addr[1:0]:
  - SB: be = 4'b0001<<a; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011<<{a[1],0}; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata unchanged.
  - Loads drive be = 4'b1111.
- Misalignment check (funct3[1:0]):
  - Misaligned if size 01 with a[0]=1, or size 10 with a!=0.
  - A misaligned op does not enter BUSY and issues no bus request.
  - The next cycle pulses o_fault=1 with o_fault_addr = the address, and forces o_reg_write=0.
- Stall: o_stall = (state==BUSY) && !i_dbus_ack && !timeout.
  - On the ack cycle, o_stall=0, so a new instruction loads on that edge. Back-to-back accesses give one bubble-free handoff.
- Outputs to rv_write:
  - All fields come combinationally from the pipeline register. o_data = i_dbus_rdata.
  - o_reg_write = r_reg_write && !(state==BUSY && !i_dbus_ack) && !fault.
  - So while waiting, rv_write samples a bubble. On the ack cycle it samples the complete load.
  - Non-memory instructions pass through with 0 wait cycles.
- Timeout:
  - The counter resets to 0 on entering BUSY and increments every BUSY cycle without ack.
  - When the count reaches TIMEOUT-1 without ack: o_fault pulses, o_reg_write=0, the state returns to IDLE, the stall releases and the request drops.
  - A late ack while in IDLE is ignored.
- Simultaneous events:
  - Ack and timeout on the same cycle: ack wins, no fault.
  - Asynchronous reset mid-BUSY: req drops immediately and the access is abandoned.

Decomposition:
- Shared package (rv_defines):
  - MEM_SIZE_B/H/W funct3 encodings (000/001/010).
  - RESULT_SRC_* (already present).
  - The rv_mem_state_t enum {IDLE, BUSY}.
- Sub-module rv_store_align, purely combinational: addr[1:0], funct3 and wdata in; be, aligned wdata and misaligned out.

Test Plan:
- SW to 0x100 with data 0xDEADBEEF, ack after 3 cycles -> req held 3 cycles, be=1111, addr=0x40, o_stall=1 for 2 cycles then 0 on the ack cycle, o_reg_write=0.
- SB to 0x203 with data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5. SH to 0x202 -> be=1100.
- LW from 0x10, rd=5, rdata=0x12345678, ack on the first BUSY cycle -> o_data=0x12345678 and o_reg_write=1 on the ack cycle only. The next ADD enters with no extra bubble.
- LH from 0x101 -> no req, o_fault pulse, o_fault_addr=0x101, o_reg_write=0.
- TIMEOUT=4, load with no ack -> req for 4 cycles, o_fault on the 4th, stall released, a later ack is ignored.
- Drop i_reset_n mid-BUSY -> o_dbus_req=0 asynchronously. After release, o_stall=0 and the stage holds a bubble. i_flush during IDLE -> the next cycle has o_reg_write=0.

Source files
------------

// File: rtl/rv_defines.sv
// Shared RV32I definitions: load/store size encodings, result select and
// the memory-stage state type.
package rv_defines;

    localparam logic [2:0] MEM_SIZE_B = 3'b000;
    localparam logic [2:0] MEM_SIZE_H = 3'b001;
    localparam logic [2:0] MEM_SIZE_W = 3'b010;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} rv_mem_state_t;

    // Sign bit of funct3 is irrelevant to alignment; only the size matters.
    function automatic logic mem_misaligned(input logic [2:0] funct3, input logic [1:0] a);
        logic [2:0] sz;
        sz = {1'b0, funct3[1:0]};
        return ((sz == MEM_SIZE_H) && a[0]) || ((sz == MEM_SIZE_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/rv_store_align.sv
// Store lane alignment: byte enables, replicated store data and the
// misalignment flag for one access.
module rv_store_align
    import rv_defines::*;
(
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case ({1'b0, funct3_i[1:0]})
            MEM_SIZE_B: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                be_o    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign misaligned_o = mem_misaligned(funct3_i, addr_i);

endmodule

// File: rtl/rv_memory.sv
// Memory-access stage: pipeline register, req/ack bus FSM with timeout,
// store alignment, stall generation and access-fault reporting.
module rv_memory
    import rv_defines::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_res_src,
    input  logic [29:0] i_pc_p4,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [29:0] o_dbus_addr,
    output logic [3:0]  o_dbus_be,
    output logic [31:0] o_dbus_wdata,
    input  logic [31:0] i_dbus_rdata,
    input  logic        i_dbus_ack,
    output logic [31:0] o_data,
    output logic [31:0] o_alu_result,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [1:0]  o_res_src,
    output logic [29:0] o_pc_p4,
    output logic [2:0]  o_funct3,
    output logic        o_fault,
    output logic [31:0] o_fault_addr
);

    logic [31:0]   alu_q, wdata_q;
    logic          mem_read_q, mem_write_q, reg_write_q;
    logic [4:0]    rd_q;
    logic [1:0]    res_src_q;
    logic [29:0]   pc_p4_q;
    logic [2:0]    funct3_q;
    rv_mem_state_t state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;

    logic        busy, timeout, mis_fault, fault, in_mem_ok, misaligned_q;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign busy    = (state_q == BUSY);
    // Ack takes precedence over an expiring counter.
    assign timeout = busy && !i_dbus_ack && (cnt_q == 8'(TIMEOUT - 1));
    assign o_stall = busy && !i_dbus_ack && !timeout;

    assign in_mem_ok = !i_flush && (i_mem_read || i_mem_write)
                       && !mem_misaligned(i_funct3, i_alu_result[1:0]);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            alu_q       <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            res_src_q   <= '0;
            pc_p4_q     <= '0;
            funct3_q    <= '0;
        end else if (!o_stall) begin
            if (i_flush) begin
                alu_q       <= '0;
                wdata_q     <= '0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                reg_write_q <= 1'b0;
                rd_q        <= '0;
                res_src_q   <= '0;
                pc_p4_q     <= '0;
                funct3_q    <= '0;
            end else begin
                alu_q       <= i_alu_result;
                wdata_q     <= i_wdata;
                mem_read_q  <= i_mem_read;
                mem_write_q <= i_mem_write;
                reg_write_q <= i_reg_write;
                rd_q        <= i_rd;
                res_src_q   <= i_res_src;
                pc_p4_q     <= i_pc_p4;
                funct3_q    <= i_funct3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Whenever the register loads (idle, ack or timeout) the state follows
    // the incoming op, which gives a bubble-free handoff between accesses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!o_stall) begin
            state_d = in_mem_ok ? BUSY : IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d   = cnt_q + 8'd1;
        end
    end

    rv_store_align u_align (
        .addr_i       (alu_q[1:0]),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .be_o         (st_be),
        .wdata_o      (st_wdata),
        .misaligned_o (misaligned_q)
    );

    assign mis_fault = !busy && (mem_read_q || mem_write_q) && misaligned_q;
    assign fault     = mis_fault || timeout;

    assign o_dbus_req   = busy;
    assign o_dbus_we    = mem_write_q;
    assign o_dbus_addr  = alu_q[31:2];
    assign o_dbus_be    = mem_write_q ? st_be : (mem_read_q ? 4'b1111 : 4'b0000);
    assign o_dbus_wdata = st_wdata;

    assign o_data       = i_dbus_rdata;
    assign o_alu_result = alu_q;
    assign o_reg_write  = reg_write_q && !(busy && !i_dbus_ack) && !fault;
    assign o_rd         = rd_q;
    assign o_res_src    = res_src_q;
    assign o_pc_p4      = pc_p4_q;
    assign o_funct3     = funct3_q;
    assign o_fault      = fault;
    assign o_fault_addr = fault ? alu_q : 32'd0;

endmodule

// File: tb/tb_rv_memory.sv
// Directed bench for rv_memory: stores, loads, misalignment, timeout,
// reset and flush, each checked against hand-computed values.
module tb_rv_memory;

    logic        i_clk = 1'b0;
    logic        i_reset_n, i_flush;
    logic [31:0] i_alu_result, i_wdata, i_dbus_rdata;
    logic        i_mem_read, i_mem_write, i_reg_write, i_dbus_ack;
    logic [4:0]  i_rd;
    logic [1:0]  i_res_src;
    logic [29:0] i_pc_p4;
    logic [2:0]  i_funct3;
    logic        o_stall, o_dbus_req, o_dbus_we, o_reg_write, o_fault;
    logic [29:0] o_dbus_addr, o_pc_p4;
    logic [3:0]  o_dbus_be;
    logic [31:0] o_dbus_wdata, o_data, o_alu_result, o_fault_addr;
    logic [4:0]  o_rd;
    logic [1:0]  o_res_src;
    logic [2:0]  o_funct3;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    rv_memory #(.TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_alu_result(i_alu_result), .i_wdata(i_wdata),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
        .i_rd(i_rd), .i_res_src(i_res_src), .i_pc_p4(i_pc_p4), .i_funct3(i_funct3),
        .o_stall(o_stall), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
        .o_dbus_addr(o_dbus_addr), .o_dbus_be(o_dbus_be), .o_dbus_wdata(o_dbus_wdata),
        .i_dbus_rdata(i_dbus_rdata), .i_dbus_ack(i_dbus_ack),
        .o_data(o_data), .o_alu_result(o_alu_result), .o_reg_write(o_reg_write),
        .o_rd(o_rd), .o_res_src(o_res_src), .o_pc_p4(o_pc_p4), .o_funct3(o_funct3),
        .o_fault(o_fault), .o_fault_addr(o_fault_addr)
    );

    task automatic drive(input logic mr, input logic mw, input logic rw, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        i_mem_read = mr; i_mem_write = mw; i_reg_write = rw; i_rd = rd;
        i_alu_result = addr; i_wdata = wd; i_funct3 = f3;
        i_res_src = mr ? 2'b01 : 2'b00; i_pc_p4 = 30'h100;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 3'd0);
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_dbus_ack = 1'b0; i_dbus_rdata = '0; nop();
        @(posedge i_clk); #2;
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", o_stall); end
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", o_dbus_req); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0h exp 0", o_fault); end
        checks++; if ({o_reg_write, o_rd, o_alu_result, o_dbus_be} !== '0) begin errors++; $display("FAIL rst_fields got %0h exp 0", {o_reg_write, o_rd, o_alu_result, o_dbus_be}); end
        @(negedge i_clk); i_reset_n = 1'b1;
    endtask

    task automatic test_sw();
        @(negedge i_clk); drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, 3'b010);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk); nop(); i_dbus_ack = (k == 2); #1;
            checks++; if (o_dbus_req !== 1'b1) begin errors++; $display("FAIL sw_req[%0d] got %0h exp 1", k, o_dbus_req); end
            checks++; if (o_stall !== (k < 2)) begin errors++; $display("FAIL sw_stall[%0d] got %0h exp %0h", k, o_stall, (k < 2)); end
            checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL sw_rw[%0d] got %0h exp 0", k, o_reg_write); end
        end
        checks++; if ({o_dbus_we, o_dbus_be, o_dbus_addr} !== {1'b1, 4'hF, 30'h40}) begin errors++; $display("FAIL sw_bus got we=%0h be=%0h addr=%0h exp 1/f/40", o_dbus_we, o_dbus_be, o_dbus_addr); end
        checks++; if (o_dbus_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", o_dbus_wdata); end
        @(negedge i_clk); i_dbus_ack = 1'b0; #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop got %0h exp 0", o_dbus_req); end
    endtask

    task automatic test_back_to_back();
        @(negedge i_clk); drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h203, 32'h000000A5, 3'b000);
        @(negedge i_clk); drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h202, 32'h00001234, 3'b001); i_dbus_ack = 1'b1; #1;
        checks++; if (o_dbus_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", o_dbus_be); end
        checks++; if (o_dbus_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_dbus_wdata); end
        checks++; if (o_dbus_addr !== 30'h80) begin errors++; $display("FAIL sb_addr got %h exp 80", o_dbus_addr); end
        @(negedge i_clk); nop(); #1;
        checks++; if (o_dbus_req !== 1'b1) begin errors++; $display("FAIL sh_req got %0h exp 1", o_dbus_req); end
        checks++; if (o_dbus_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", o_dbus_be); end
        checks++; if (o_dbus_wdata !== 32'h12341234) begin errors++; $display("FAIL sh_wdata got %h exp 12341234", o_dbus_wdata); end
        @(negedge i_clk); i_dbus_ack = 1'b0; #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL sh_req_drop got %0h exp 0", o_dbus_req); end
    endtask

    task automatic test_lw();
        @(negedge i_clk); drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h10, 32'd0, 3'b010);
        @(negedge i_clk); drive(1'b0, 1'b0, 1'b1, 5'd6, 32'h55, 32'd0, 3'b000); #1;
        checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL lw_rw_wait got %0h exp 0", o_reg_write); end
        checks++; if ({o_dbus_be, o_dbus_addr, o_dbus_we} !== {4'hF, 30'h4, 1'b0}) begin errors++; $display("FAIL lw_bus got be=%0h addr=%0h we=%0h exp f/4/0", o_dbus_be, o_dbus_addr, o_dbus_we); end
        i_dbus_ack = 1'b1; i_dbus_rdata = 32'h12345678; #1;
        checks++; if (o_data !== 32'h12345678) begin errors++; $display("FAIL lw_data got %h exp 12345678", o_data); end
        checks++; if ({o_reg_write, o_rd, o_stall} !== {1'b1, 5'd5, 1'b0}) begin errors++; $display("FAIL lw_ack got rw=%0h rd=%0d stall=%0h exp 1/5/0", o_reg_write, o_rd, o_stall); end
        @(negedge i_clk); nop(); i_dbus_ack = 1'b0; i_dbus_rdata = '0; #1;
        checks++; if ({o_reg_write, o_rd, o_alu_result} !== {1'b1, 5'd6, 32'h55}) begin errors++; $display("FAIL add_next got rw=%0h rd=%0d alu=%h exp 1/6/55", o_reg_write, o_rd, o_alu_result); end
        checks++; if ({o_dbus_req, o_stall} !== 2'b00) begin errors++; $display("FAIL add_idle got %b exp 00", {o_dbus_req, o_stall}); end
    endtask

    task automatic test_misaligned();
        @(negedge i_clk); drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h101, 32'd0, 3'b001);
        @(negedge i_clk); nop(); #1;
        checks++; if ({o_dbus_req, o_stall} !== 2'b00) begin errors++; $display("FAIL mis_req got %b exp 00", {o_dbus_req, o_stall}); end
        checks++; if (o_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %0h exp 1", o_fault); end
        checks++; if (o_fault_addr !== 32'h101) begin errors++; $display("FAIL mis_addr got %h exp 101", o_fault_addr); end
        checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL mis_rw got %0h exp 0", o_reg_write); end
        @(negedge i_clk); #1;
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL mis_pulse got %0h exp 0", o_fault); end
    endtask

    task automatic test_timeout();
        @(negedge i_clk); drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h20, 32'd0, 3'b010);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk); nop(); #1;
            checks++; if (o_dbus_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d] got %0h exp 1", k, o_dbus_req); end
            checks++; if ({o_stall, o_fault} !== {(k < 3), (k == 3)}) begin errors++; $display("FAIL to_sf[%0d] got %b exp %b", k, {o_stall, o_fault}, {(k < 3), (k == 3)}); end
            checks++; if (o_reg_write !== 1'b0) begin errors++; $display("FAIL to_rw[%0d] got %0h exp 0", k, o_reg_write); end
        end
        checks++; if (o_fault_addr !== 32'h20) begin errors++; $display("FAIL to_addr got %h exp 20", o_fault_addr); end
        @(negedge i_clk); i_dbus_ack = 1'b1; #1;
        checks++; if ({o_dbus_req, o_reg_write, o_fault, o_stall} !== 4'b0000) begin errors++; $display("FAIL to_late_ack got %b exp 0000", {o_dbus_req, o_reg_write, o_fault, o_stall}); end
        @(negedge i_clk); i_dbus_ack = 1'b0; #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL to_after got %0h exp 0", o_dbus_req); end
    endtask

    task automatic test_reset_mid_busy();
        @(negedge i_clk); drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'h1, 3'b010);
        @(negedge i_clk); nop(); #1;
        checks++; if (o_dbus_req !== 1'b1) begin errors++; $display("FAIL rb_req got %0h exp 1", o_dbus_req); end
        #1 i_reset_n = 1'b0; #1;
        checks++; if (o_dbus_req !== 1'b0) begin errors++; $display("FAIL rb_async got %0h exp 0", o_dbus_req); end
        @(negedge i_clk); i_reset_n = 1'b1; #1;
        checks++; if ({o_stall, o_reg_write, o_dbus_we, o_alu_result} !== '0) begin errors++; $display("FAIL rb_bubble got %h exp 0", {o_stall, o_reg_write, o_dbus_we, o_alu_result}); end
    endtask

    task automatic test_flush();
        @(negedge i_clk); drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h30, 32'd0, 3'b010); i_flush = 1'b1;
        @(negedge i_clk); nop(); #1;
        checks++; if ({o_reg_write, o_rd, o_dbus_req} !== {1'b0, 5'd0, 1'b0}) begin errors++; $display("FAIL fl_idle got %b exp 0", {o_reg_write, o_rd, o_dbus_req}); end
        // Flush while stalled must not disturb the waiting load.
        @(negedge i_clk); drive(1'b1, 1'b0, 1'b1, 5'd12, 32'h34, 32'd0, 3'b010);
        @(negedge i_clk); nop(); i_flush = 1'b1;
        @(negedge i_clk); i_flush = 1'b0; i_dbus_ack = 1'b1; #1;
        checks++; if ({o_reg_write, o_rd} !== {1'b1, 5'd12}) begin errors++; $display("FAIL fl_busy got rw=%0h rd=%0d exp 1/12", o_reg_write, o_rd); end
        @(negedge i_clk); i_dbus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_back_to_back();
        test_lw();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
